// File: rtl/rob_pkg.sv
// Shared reorder-buffer types and the live-window helper used by the commit controller.
package rob_pkg;

    localparam int ROB_ID_W  = 4;
    localparam int ROB_DEPTH = 1 << ROB_ID_W;

    typedef logic [ROB_ID_W-1:0] rob_id_t;
    typedef logic [ROB_ID_W:0]   rob_ptr_t;

    // An id is live when its distance from head is below the occupancy; this stays correct when full.
    function automatic logic rob_in_window(input rob_ptr_t head, input rob_ptr_t tail, input rob_id_t id);
        rob_id_t  offset;
        rob_ptr_t occ;
        offset = id - head[ROB_ID_W-1:0];
        occ    = tail - head;
        return ({1'b0, offset} < occ);
    endfunction

endpackage

// File: rtl/commit_rob_done_vec.sv
// Per-entry completion flags: set by writeback, cleared by alloc or commit, wiped on reset/flush.
module commit_rob_done_vec
    import rob_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 set_en,
    input  rob_id_t              set_id,
    input  logic                 alloc_clr_en,
    input  rob_id_t              alloc_clr_id,
    input  logic                 commit_clr_en,
    input  rob_id_t              commit_clr_id,
    output logic [ROB_DEPTH-1:0] done
);

    logic [ROB_DEPTH-1:0] done_reg;

    generate
        for (genvar gi = 0; gi < ROB_DEPTH; gi++) begin : g_done
            localparam rob_id_t IDX = rob_id_t'(gi);
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    done_reg[gi] <= 1'b0;
                end else if ((alloc_clr_en && alloc_clr_id == IDX) ||
                             (commit_clr_en && commit_clr_id == IDX)) begin
                    done_reg[gi] <= 1'b0;
                end else if (set_en && set_id == IDX) begin
                    done_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    assign done = done_reg;

endmodule

// File: rtl/commit_rob_ctrl.sv
// In-order 16-entry ROB commit controller: id allocation, writeback tracking, head retirement, flush.
// Optional writeback legality flag enabled by defining COMMIT_ROB_CTRL_WB_CHECK_EN.
module commit_rob_ctrl
    import rob_pkg::*;
#(
    parameter int READYN_MARGIN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              snoop_hit,
    input  logic              bco_valid,
    input  logic              alloc_valid,
    output logic [ROB_ID_W-1:0] alloc_id,
    output logic              alloc_readyn,
    input  logic              wb_valid,
    input  logic [ROB_ID_W-1:0] wb_id,
    output logic              commit_valid,
    output logic [ROB_ID_W-1:0] commit_id,
    input  logic              commit_ready,
    output logic [ROB_ID_W:0] count,
    output logic              empty,
    output logic              wb_err
);

    rob_ptr_t             head_reg, head_next;
    rob_ptr_t             tail_reg, tail_next;
    rob_ptr_t             free_slots;
    logic [ROB_DEPTH-1:0] done;
    logic                 flush;
    logic                 full;
    logic                 wb_in_window;
    logic                 alloc_fire;
    logic                 wb_fire;
    logic                 commit_fire;

    assign flush        = snoop_hit | bco_valid;
    assign count        = tail_reg - head_reg;
    assign full         = (count == rob_ptr_t'(ROB_DEPTH));
    assign empty        = (count == '0);
    assign free_slots   = rob_ptr_t'(ROB_DEPTH) - count;
    assign alloc_readyn = (free_slots <= rob_ptr_t'(READYN_MARGIN));
    assign alloc_id     = tail_reg[ROB_ID_W-1:0];
    assign commit_id    = head_reg[ROB_ID_W-1:0];

    assign wb_in_window = rob_in_window(head_reg, tail_reg, wb_id);

    // Full is taken from registered state, so a same-cycle commit never frees room for an alloc.
    assign alloc_fire   = alloc_valid & ~full & ~flush;
    assign wb_fire      = wb_valid & wb_in_window & ~flush;
    assign commit_valid = ~empty & done[commit_id] & ~flush;
    assign commit_fire  = commit_valid & commit_ready;

    always_comb begin
        head_next = head_reg;
        tail_next = tail_reg;
        if (flush) begin
            head_next = '0;
            tail_next = '0;
        end else begin
            if (commit_fire) head_next = head_reg + rob_ptr_t'(1);
            if (alloc_fire)  tail_next = tail_reg + rob_ptr_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
        end
    end

    commit_rob_done_vec u_done_vec (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .set_en        (wb_fire),
        .set_id        (wb_id),
        .alloc_clr_en  (alloc_fire),
        .alloc_clr_id  (alloc_id),
        .commit_clr_en (commit_fire),
        .commit_clr_id (commit_id),
        .done          (done)
    );

`ifdef COMMIT_ROB_CTRL_WB_CHECK_EN
    logic wb_err_reg;
    logic wb_err_next;

    assign wb_err_next = wb_valid & (~wb_in_window | done[wb_id]);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wb_err_reg <= 1'b0;
        end else begin
            wb_err_reg <= wb_err_next;
        end
    end

    assign wb_err = wb_err_reg;
`else
    assign wb_err = 1'b0;
`endif

endmodule

// File: tb/tb_commit_rob_ctrl.sv
// Directed self-checking bench for commit_rob_ctrl (fill, commit order, wrap, flush, wb legality).
module tb_commit_rob_ctrl;
    import rob_pkg::*;

    logic       clk;
    logic       reset;
    logic       snoop_hit;
    logic       bco_valid;
    logic       alloc_valid;
    logic [3:0] alloc_id;
    logic       alloc_readyn;
    logic       wb_valid;
    logic [3:0] wb_id;
    logic       commit_valid;
    logic [3:0] commit_id;
    logic       commit_ready;
    logic [4:0] count;
    logic       empty;
    logic       wb_err;

    int total_cnt = 0;
    int bad_cnt   = 0;

`ifdef COMMIT_ROB_CTRL_WB_CHECK_EN
    localparam int ERR_EXP = 1;
`else
    localparam int ERR_EXP = 0;
`endif

    commit_rob_ctrl #(.READYN_MARGIN(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .snoop_hit    (snoop_hit),
        .bco_valid    (bco_valid),
        .alloc_valid  (alloc_valid),
        .alloc_id     (alloc_id),
        .alloc_readyn (alloc_readyn),
        .wb_valid     (wb_valid),
        .wb_id        (wb_id),
        .commit_valid (commit_valid),
        .commit_id    (commit_id),
        .commit_ready (commit_ready),
        .count        (count),
        .empty        (empty),
        .wb_err       (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0d want=%0d t=%0t", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; snoop_hit = 1'b0; bco_valid = 1'b0;
        alloc_valid = 1'b0; wb_valid = 1'b0; wb_id = '0; commit_ready = 1'b0;
        do_reset();
        #1;
        check_eq("rst_count", count, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_alloc_id", alloc_id, 0);
        check_eq("rst_readyn", alloc_readyn, 0);
        check_eq("rst_cv", commit_valid, 0);
        check_eq("rst_commit_id", commit_id, 0);
        check_eq("rst_wb_err", wb_err, 0);

        // Fill 16 back-to-back, throttle from count 12, 17th alloc dropped
        alloc_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            check_eq("fill_alloc_id", alloc_id, i);
            check_eq("fill_readyn", alloc_readyn, (i >= 12) ? 1 : 0);
            tick();
        end
        #1;
        check_eq("full_count", count, 16);
        check_eq("full_empty", empty, 0);
        tick();
        check_eq("drop17_count", count, 16);
        alloc_valid = 1'b0;

        // Allocate 3, wb 2,1,0 then commits 0,1,2
        do_reset();
        alloc_valid = 1'b1;
        repeat (3) tick();
        alloc_valid = 1'b0;
        commit_ready = 1'b1;
        wb_valid = 1'b1; wb_id = 4'd2; tick();
        #1; check_eq("ooo_cv_after_wb2", commit_valid, 0);
        wb_id = 4'd1; tick();
        wb_id = 4'd0;
        #1; check_eq("ooo_cv_same_wb0", commit_valid, 0);
        tick();
        wb_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("ooo_cv", commit_valid, 1);
            check_eq("ooo_commit_id", commit_id, i);
            tick();
        end
        check_eq("ooo_empty", empty, 1);
        check_eq("ooo_cv_end", commit_valid, 0);

        // Fill, complete everything while stalled, then drain 16 in order
        do_reset();
        commit_ready = 1'b0;
        alloc_valid = 1'b1;
        repeat (16) tick();
        alloc_valid = 1'b0;
        wb_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wb_id = 4'(i);
            tick();
        end
        wb_valid = 1'b0;
        #1;
        check_eq("drain_count0", count, 16);
        commit_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            check_eq("drain_cv", commit_valid, 1);
            check_eq("drain_commit_id", commit_id, i);
            tick();
        end
        check_eq("drain_count", count, 0);
        check_eq("drain_empty", empty, 1);
        commit_ready = 1'b0;

        // Wrap: head 14, tail 15, then concurrent alloc/commit/wb across 15->0
        do_reset();
        alloc_valid = 1'b1;
        repeat (15) tick();
        alloc_valid = 1'b0;
        wb_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            wb_id = 4'(i);
            tick();
        end
        wb_valid = 1'b0;
        commit_ready = 1'b1;
        repeat (14) tick();
        check_eq("wrap_pre_count", count, 1);
        check_eq("wrap_pre_commit_id", commit_id, 14);
        check_eq("wrap_pre_alloc_id", alloc_id, 15);
        alloc_valid = 1'b1;
        #1; check_eq("wrap_pre_cv", commit_valid, 1);
        tick();
        check_eq("wrapA_count", count, 1);
        check_eq("wrapA_alloc_id", alloc_id, 0);
        check_eq("wrapA_cv", commit_valid, 0);
        wb_valid = 1'b1; wb_id = 4'd15;
        tick();
        wb_id = 4'd0;
        #1;
        check_eq("wrapB_count", count, 2);
        check_eq("wrapB_alloc_id", alloc_id, 1);
        check_eq("wrapB_cv", commit_valid, 1);
        check_eq("wrapB_commit_id", commit_id, 15);
        tick();
        check_eq("wrapC_count", count, 2);
        check_eq("wrapC_alloc_id", alloc_id, 2);
        check_eq("wrapC_cv", commit_valid, 1);
        check_eq("wrapC_commit_id", commit_id, 0);
        alloc_valid = 1'b0; wb_valid = 1'b0; commit_ready = 1'b0;

        // Flush with bco_valid, then snoop_hit: same-cycle alloc/commit discarded
        for (int k = 0; k < 2; k++) begin
            do_reset();
            alloc_valid = 1'b1;
            repeat (5) tick();
            alloc_valid = 1'b0;
            wb_valid = 1'b1; wb_id = 4'd0;
            tick();
            wb_valid = 1'b0;
            #1;
            check_eq(k == 0 ? "bco_pre_cv" : "snp_pre_cv", commit_valid, 1);
            check_eq(k == 0 ? "bco_pre_count" : "snp_pre_count", count, 5);
            if (k == 0) bco_valid = 1'b1; else snoop_hit = 1'b1;
            alloc_valid = 1'b1; commit_ready = 1'b1;
            #1;
            check_eq(k == 0 ? "bco_cv" : "snp_cv", commit_valid, 0);
            tick();
            bco_valid = 1'b0; snoop_hit = 1'b0; alloc_valid = 1'b0; commit_ready = 1'b0;
            #1;
            check_eq(k == 0 ? "bco_count" : "snp_count", count, 0);
            check_eq(k == 0 ? "bco_alloc_id" : "snp_alloc_id", alloc_id, 0);
            check_eq(k == 0 ? "bco_empty" : "snp_empty", empty, 1);
        end

        // Writeback legality: unallocated id, then a legal wb, then a duplicate
        alloc_valid = 1'b1; tick(); alloc_valid = 1'b0;
        wb_valid = 1'b1; wb_id = 4'd5; tick(); wb_valid = 1'b0;
        #1;
        check_eq("err_unalloc", wb_err, ERR_EXP);
        check_eq("err_unalloc_cv", commit_valid, 0);
        tick();
        check_eq("err_unalloc_pulse_end", wb_err, 0);
        wb_valid = 1'b1; wb_id = 4'd0; tick(); wb_valid = 1'b0;
        #1;
        check_eq("err_legal", wb_err, 0);
        check_eq("err_legal_cv", commit_valid, 1);
        wb_valid = 1'b1; wb_id = 4'd0; tick(); wb_valid = 1'b0;
        #1;
        check_eq("err_dup", wb_err, ERR_EXP);
        check_eq("err_dup_cv", commit_valid, 1);
        tick();
        check_eq("err_dup_pulse_end", wb_err, 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
